// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port data SRAM bank between NUM_REQ requesters
//   (MVP core, matrix-inversion unit, input loader, output write-back reader).
//   The grant is round-robin. A requester can lock the bank for a burst.
//   hold stops new grants without disturbing reads already in flight.
//   Read data comes back MEM_LATENCY cycles after the transfer and is tagged
//   with the requester that issued it.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   hold                1: no new grants
//   req_vld/req_rdy     per-requester handshake; req_rdy is one-hot
//   req_wen, req_lock   per-requester write flag and burst lock
//   req_addr, req_wdata packed per-requester fields, requester i at [i*W +: W]
//   rsp_vld, rsp_rdata  one-cycle response pulse and broadcast read data
//   mem_*               SRAM interface (csb/web active-low)
//   grant_id            index of the current/last granted requester
module data_mem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  input  logic [NUM_REQ-1:0]             req_vld,
  output logic [NUM_REQ-1:0]             req_rdy,
  input  logic [NUM_REQ-1:0]             req_wen,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_vld,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           mem_csb,
  output logic                           mem_web,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [IDW-1:0]                 grant_id
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t                  state;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          owner;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [IDW-1:0]          pick;
  logic                    pick_found;
  logic [IDW-1:0]          scan;
  logic [IDW-1:0]          gidx;
  logic                    xfer;
  logic [ADDR_WIDTH-1:0]   g_addr;
  logic [DATA_WIDTH-1:0]   g_wdata;

  logic                    vld_p [MEM_LATENCY];
  logic [IDW-1:0]          id_p  [MEM_LATENCY];

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + IDW'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Round-robin search starting at rr_ptr.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_vld[scan]) begin
        pick_found = 1'b1;
        pick       = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // While locked, only the owner can be served. The rst gate forces the
  // grant low as soon as reset is asserted.
  always_comb begin
    gidx    = (state == LOCKED) ? owner : pick;
    xfer    = ~rst & ~hold & ((state == LOCKED) ? req_vld[owner] : pick_found);
    req_rdy = xfer ? onehot(gidx) : '0;
    g_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    g_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
  end

  // The SRAM bus shows the granted request in the same cycle. When idle,
  // address and data keep the last driven values.
  always_comb begin
    mem_csb   = ~xfer;
    mem_web   = xfer ? ~req_wen[gidx] : 1'b1;
    mem_addr  = xfer ? g_addr  : addr_q;
    mem_wdata = xfer ? g_wdata : wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      rr_ptr   <= '0;
      owner    <= '0;
      grant_id <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (xfer) begin
        grant_id <= gidx;
        addr_q   <= g_addr;
        wdata_q  <= g_wdata;
      end
      case (state)
        ARB: begin
          if (xfer) begin
            if (req_lock[gidx]) begin
              // rr_ptr is left alone during a burst. It advances past the
              // owner when the lock is released.
              state <= LOCKED;
              owner <= gidx;
            end else begin
              rr_ptr <= wrap_inc(gidx);
            end
          end
        end
        LOCKED: begin
          // If the owner drops valid, the lock ends. hold alone keeps it.
          if (!req_vld[owner] || (xfer && !req_lock[owner])) begin
            state  <= ARB;
            rr_ptr <= wrap_inc(owner);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  // ---- response pipe stage 0: capture accepted reads ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p[0] <= 1'b0;
    else     vld_p[0] <= xfer & ~req_wen[gidx];
  end

  always_ff @(posedge clk) begin
    id_p[0] <= gidx;
  end

  // ---- response pipe stages 1..MEM_LATENCY-1 ----
  for (genvar s = 1; s < MEM_LATENCY; s++) begin : g_pipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p[s] <= 1'b0;
      else     vld_p[s] <= vld_p[s-1];
    end

    always_ff @(posedge clk) begin
      id_p[s] <= id_p[s-1];
    end
  end

  // ---- response output: last stage lines up with SRAM read data ----
  always_comb begin
    rsp_vld   = vld_p[MEM_LATENCY-1] ? onehot(id_p[MEM_LATENCY-1]) : '0;
    rsp_rdata = mem_rdata;
  end

endmodule
